// File: rtl/cpu_pkg.sv
// Shared SimpleCPU datapath types and constants.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/reg_files_if.sv
// Register-file access bundle: decode drives read addresses, writeback drives the write port.
interface reg_files_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic              we3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (
    output a1, a2, a3, wd3, we3,
    input  rd1, rd2
  );

  modport slave (
    input  a1, a2, a3, wd3, we3,
    output rd1, rd2
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: zero register, optional write-first forwarding, stored value.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic fwd;

  // Reset suppresses forwarding because the write it would mirror never lands.
  assign fwd = (BYPASS != 0) && wr_en_i && !rst_i && (wr_addr_i == addr_i);

  always_comb begin
    rdata_o = stored_i;
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      rdata_o = '0;
    end else if (fwd) begin
      rdata_o = wr_data_i;
    end
  end

endmodule

// File: rtl/reg_files.sv
// Three-port register file: two combinational reads, one synchronous write, r0 hardwired to zero.
module reg_files
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  reg_files_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      regs_d = '{default: '0};
    end else if (bus.we3 && (bus.a3 != ADDR_W'(REG_ZERO))) begin
      regs_d[bus.a3] = bus.wd3;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port1 (
    .addr_i    (bus.a1),
    .stored_i  (regs_q[bus.a1]),
    .rst_i     (rst),
    .wr_en_i   (bus.we3),
    .wr_addr_i (bus.a3),
    .wr_data_i (bus.wd3),
    .rdata_o   (bus.rd1)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port2 (
    .addr_i    (bus.a2),
    .stored_i  (regs_q[bus.a2]),
    .rst_i     (rst),
    .wr_en_i   (bus.we3),
    .wr_addr_i (bus.a3),
    .wr_data_i (bus.wd3),
    .rdata_o   (bus.rd2)
  );

endmodule

// File: tb/tb_reg_files.sv
// Directed bench for reg_files; a BYPASS=1 and a BYPASS=0 instance see identical stimulus.
module tb_reg_files;

  logic        clk;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we3;

  int vectors;
  int miscompares;

  reg_files_if #(.DATA_W(32), .ADDR_W(5)) bus_bp ();
  reg_files_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

  assign bus_bp.a1  = a1;
  assign bus_bp.a2  = a2;
  assign bus_bp.a3  = a3;
  assign bus_bp.wd3 = wd3;
  assign bus_bp.we3 = we3;
  assign bus_nb.a1  = a1;
  assign bus_nb.a2  = a2;
  assign bus_nb.a3  = a3;
  assign bus_nb.wd3 = wd3;
  assign bus_nb.we3 = we3;

  reg_files #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_bp (
    .clk (clk),
    .rst (rst),
    .bus (bus_bp.slave)
  );

  reg_files #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after that.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    a3 = a; wd3 = d; we3 = 1'b1;
    @(posedge clk); #1;
    we3 = 1'b0;
  endtask

  task automatic test_reset();
    a1 = 5'd0; a2 = 5'd3; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h0 || bus_nb.rd1 !== 32'h0) begin
      $display("FAIL reset_r0: bp=%h nb=%h want 00000000", bus_bp.rd1, bus_nb.rd1);
      miscompares++;
    end
    vectors++;
    if (bus_bp.rd2 !== 32'h0 || bus_nb.rd2 !== 32'h0) begin
      $display("FAIL reset_r3: bp=%h nb=%h want 00000000", bus_bp.rd2, bus_nb.rd2);
      miscompares++;
    end
    wr(5'd5, 32'hDEADBEEF);
    a1 = 5'd5; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'hDEADBEEF) begin
      $display("FAIL prefill_r5: got %h want deadbeef", bus_bp.rd1);
      miscompares++;
    end
    // Reset with a competing write; reset must win and must not be forwarded.
    rst = 1'b1; we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1234; a2 = 5'd7; #1;
    vectors++;
    if (bus_bp.rd2 === 32'h1234) begin
      $display("FAIL reset_no_fwd: got %h want not 00001234", bus_bp.rd2);
      miscompares++;
    end
    @(posedge clk); #1;
    rst = 1'b0; we3 = 1'b0; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h0 || bus_nb.rd1 !== 32'h0) begin
      $display("FAIL reset_clears_r5: bp=%h nb=%h want 00000000", bus_bp.rd1, bus_nb.rd1);
      miscompares++;
    end
    vectors++;
    if (bus_bp.rd2 !== 32'h0 || bus_nb.rd2 !== 32'h0) begin
      $display("FAIL reset_blocks_r7: bp=%h nb=%h want 00000000", bus_bp.rd2, bus_nb.rd2);
      miscompares++;
    end
  endtask

  task automatic test_basic_write();
    wr(5'd3, 32'hA5A5A5A5);
    a1 = 5'd3; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'hA5A5A5A5 || bus_nb.rd1 !== 32'hA5A5A5A5) begin
      $display("FAIL write_r3: bp=%h nb=%h want a5a5a5a5", bus_bp.rd1, bus_nb.rd1);
      miscompares++;
    end
    wr(5'd31, 32'h0000FFFF);
    a2 = 5'd31; #1;
    vectors++;
    if (bus_bp.rd2 !== 32'h0000FFFF || bus_nb.rd2 !== 32'h0000FFFF) begin
      $display("FAIL write_r31: bp=%h nb=%h want 0000ffff", bus_bp.rd2, bus_nb.rd2);
      miscompares++;
    end
  endtask

  task automatic test_zero_reg();
    a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; wd3 = 32'hFFFFFFFF; we3 = 1'b1; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h0 || bus_bp.rd2 !== 32'h0) begin
      $display("FAIL zero_before: rd1=%h rd2=%h want 00000000", bus_bp.rd1, bus_bp.rd2);
      miscompares++;
    end
    @(posedge clk); #1;
    we3 = 1'b0; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h0 || bus_nb.rd2 !== 32'h0) begin
      $display("FAIL zero_after: rd1=%h rd2=%h want 00000000", bus_bp.rd1, bus_nb.rd2);
      miscompares++;
    end
  endtask

  task automatic test_write_disable();
    wr(5'd10, 32'h11);
    a3 = 5'd10; wd3 = 32'h22; we3 = 1'b0; a1 = 5'd10;
    @(posedge clk); #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h11 || bus_nb.rd1 !== 32'h11) begin
      $display("FAIL we_low_r10: bp=%h nb=%h want 00000011", bus_bp.rd1, bus_nb.rd1);
      miscompares++;
    end
  endtask

  task automatic test_bypass();
    wr(5'd4, 32'h1);
    a3 = 5'd4; wd3 = 32'h2; we3 = 1'b1; a1 = 5'd4; a2 = 5'd4; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h2 || bus_bp.rd2 !== 32'h2) begin
      $display("FAIL bypass_on: rd1=%h rd2=%h want 00000002", bus_bp.rd1, bus_bp.rd2);
      miscompares++;
    end
    vectors++;
    if (bus_nb.rd1 !== 32'h1 || bus_nb.rd2 !== 32'h1) begin
      $display("FAIL bypass_off_before: rd1=%h rd2=%h want 00000001", bus_nb.rd1, bus_nb.rd2);
      miscompares++;
    end
    @(posedge clk); #1;
    we3 = 1'b0; #1;
    vectors++;
    if (bus_nb.rd1 !== 32'h2 || bus_bp.rd1 !== 32'h2) begin
      $display("FAIL bypass_after: nb=%h bp=%h want 00000002", bus_nb.rd1, bus_bp.rd1);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1, exp2;
    for (int i = 1; i < 32; i++) begin
      a3 = 5'(i); wd3 = 32'(i) * 32'h01010101; we3 = 1'b1;
      @(posedge clk); #1;
    end
    we3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i); #1;
      exp1 = 32'(i) * 32'h01010101;
      exp2 = 32'(31 - i) * 32'h01010101;
      vectors++;
      if (bus_bp.rd1 !== exp1 || bus_nb.rd1 !== exp1) begin
        $display("FAIL sweep_rd1[%0d]: bp=%h nb=%h want %h", i, bus_bp.rd1, bus_nb.rd1, exp1);
        miscompares++;
      end
      vectors++;
      if (bus_bp.rd2 !== exp2 || bus_nb.rd2 !== exp2) begin
        $display("FAIL sweep_rd2[%0d]: bp=%h nb=%h want %h", i, bus_bp.rd2, bus_nb.rd2, exp2);
        miscompares++;
      end
    end
    a1 = 5'd9; a2 = 5'd9; #1;
    vectors++;
    if (bus_bp.rd1 !== 32'h09090909 || bus_bp.rd2 !== bus_bp.rd1) begin
      $display("FAIL same_addr: rd1=%h rd2=%h want 09090909", bus_bp.rd1, bus_bp.rd2);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_write_disable();
    test_bypass();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
